fcore_program_sequencer: RTL and testbench
==========================================

Name: fcore_program_sequencer

Overview:
Fetch/issue controller for the fCore datapath. Drives the program-memory address, decodes only the opcode field against the shared fCore opcode set, and issues instruction words to the executor. Sequences multi-word LDC, waits on branch resolution and EFI handshakes, and terminates a program on STOP or on PC overrun. Sits between the program BRAM and the fCore decode/execute pipeline.

Parameters:
PC_WIDTH, 12, program-counter/address width
INSTRUCTION_WIDTH, 32, program word width
OPCODE_WIDTH, 5, opcode field width; the opcode is word[OPCODE_WIDTH-1:0]
PROGRAM_DEPTH, 4096, valid program words; PC overrun limit

Ports:
clock  in  1  system clock
reset  in  1  asynchronous active-low reset
start  in  1  single-cycle run request; honoured only in IDLE
prog_addr  out  PC_WIDTH  program memory address; read data returns 1 cycle later
prog_data  in  INSTRUCTION_WIDTH  program memory read data
instruction  out  INSTRUCTION_WIDTH  issued word
instruction_valid  out  1  instruction holds a word this cycle
instruction_is_const  out  1  issued word is an LDC payload, not an opcode
branch_resolved  in  1  executor has evaluated the outstanding branch
branch_taken  in  1  qualified by branch_resolved
branch_target  in  PC_WIDTH  qualified by branch_resolved
efi_start  out  1  single-cycle pulse on EFI issue
efi_done  in  1  external function complete
busy  out  1  high in all states except IDLE
done  out  1  single-cycle pulse at program end
overrun  out  1  sticky; set on PC overrun, cleared on next accepted start

Behaviour:
- Reset (asynchronous, active-low): state IDLE. prog_addr=0, instruction=0, all valid/flag/pulse outputs=0, overrun=0.
- All outputs are registered. Let fetched_pc be the address presented in the previous cycle.
- States: IDLE, PRIME, RUN, CONST, BRANCH_WAIT, EFI_WAIT.
- IDLE:
  - On start: prog_addr<=0, clear overrun, go to PRIME.
  - start outside IDLE is ignored.
- PRIME:
  - One bubble cycle: prog_addr<=prog_addr+1, instruction_valid=0, go to RUN.
- RUN: decode the opcode field of prog_data.
  - NOP/ADD/SUB/MUL/ITF/FTI/LDR/LAND/LOR/LNOT/SATP/SATN/REC/POPCNT/ABS: issue the word with valid=1 and prog_addr++.
  - LDC: issue the word and prog_addr++, then go to CONST.
  - BGT/BLE/BEQ/BNE: issue the word, hold prog_addr, go to BRANCH_WAIT.
  - EFI: issue the word, pulse efi_start, hold prog_addr, go to EFI_WAIT.
  - STOP: issue the word, pulse done the same cycle, go to IDLE.
  - Undefined opcode (>EFI): issue as NOP (word forced to 0), continue.
- CONST:
  - Issue prog_data with valid=1 and is_const=1, without decoding it.
  - prog_addr++, return to RUN.
  - Back-to-back LDC works because the payload is never decoded.
- BRANCH_WAIT:
  - valid=0 while waiting.
  - On branch_resolved: prog_addr <= branch_taken ? branch_target : fetched_pc+1, then go to PRIME.
  - Branch penalty is therefore ≥2 bubbles.
  - branch_resolved outside BRANCH_WAIT is ignored.
- EFI_WAIT:
  - valid=0 while waiting.
  - On efi_done: prog_addr <= fetched_pc+1, go to PRIME.
  - efi_done arriving in the same cycle as efi_start is not accepted; only efi_done in EFI_WAIT counts.
- Overrun:
  - Trigger: RUN/CONST would increment prog_addr past PROGRAM_DEPTH-1, or branch_target ≥ PROGRAM_DEPTH.
  - Response: issue nothing further, set overrun, pulse done, go to IDLE. No wrap-around.
- Reset mid-program: immediate return to IDLE. No done pulse. Outstanding efi/branch handshakes are abandoned.

Decomposition:
- Opcode constants come from the shared fCore ISA package.
- Add to that package:
  - a sequencer state enum;
  - an is_branch helper function;
  - OPCODE_WIDTH as a package constant.
- Optional sub-module: fcore_opcode_classifier (combinational: opcode → {normal, const_follow, branch, efi, stop, illegal}). It is reused by the executor decode.

Test Plan:
- Linear program ADD,SUB,MUL,STOP at 0..3 → valid on four consecutive cycles after one PRIME bubble; done coincides with the STOP issue; busy falls the next cycle.
- LDC at 0, payload 0x0000000F at 1, LDC at 2, payload 0x00000006 at 3 (opcode-field value 6), STOP at 4 → words 1 and 3 issued with is_const=1; payload 3 is not treated as LDC; five words issued in total.
- BNE at 5, taken, target 20, resolved 3 cycles later → no valid during wait; next issued word is from address 20. Repeat with not-taken → next word from address 6.
- EFI at 2, efi_done after 10 cycles → one efi_start pulse; valid low for ≥10 cycles; resume at address 3. A spurious efi_done while in RUN has no effect.
- PROGRAM_DEPTH=8 with no STOP → words 0..7 issued; overrun=1 and done pulse; a new start clears overrun.
- Reset asserted during BRANCH_WAIT → outputs return to reset values asynchronously. A later start runs from address 0.

Source files
------------

// File: rtl/fcore_program_sequencer_pkg.sv
// Shared fCore ISA constants plus the program-sequencer state encoding and
// the opcode classes used by the sequencer and the executor decode.
package fcore_program_sequencer_pkg;

    localparam int unsigned OPCODE_WIDTH = 5;

    localparam logic [OPCODE_WIDTH-1:0] OP_NOP    = 5'd0;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD    = 5'd1;
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB    = 5'd2;
    localparam logic [OPCODE_WIDTH-1:0] OP_MUL    = 5'd3;
    localparam logic [OPCODE_WIDTH-1:0] OP_ITF    = 5'd4;
    localparam logic [OPCODE_WIDTH-1:0] OP_FTI    = 5'd5;
    localparam logic [OPCODE_WIDTH-1:0] OP_LDC    = 5'd6;
    localparam logic [OPCODE_WIDTH-1:0] OP_LDR    = 5'd7;
    localparam logic [OPCODE_WIDTH-1:0] OP_BGT    = 5'd8;
    localparam logic [OPCODE_WIDTH-1:0] OP_BLE    = 5'd9;
    localparam logic [OPCODE_WIDTH-1:0] OP_BEQ    = 5'd10;
    localparam logic [OPCODE_WIDTH-1:0] OP_BNE    = 5'd11;
    localparam logic [OPCODE_WIDTH-1:0] OP_STOP   = 5'd12;
    localparam logic [OPCODE_WIDTH-1:0] OP_LAND   = 5'd13;
    localparam logic [OPCODE_WIDTH-1:0] OP_LOR    = 5'd14;
    localparam logic [OPCODE_WIDTH-1:0] OP_LNOT   = 5'd15;
    localparam logic [OPCODE_WIDTH-1:0] OP_SATP   = 5'd16;
    localparam logic [OPCODE_WIDTH-1:0] OP_SATN   = 5'd17;
    localparam logic [OPCODE_WIDTH-1:0] OP_REC    = 5'd18;
    localparam logic [OPCODE_WIDTH-1:0] OP_POPCNT = 5'd19;
    localparam logic [OPCODE_WIDTH-1:0] OP_ABS    = 5'd20;
    localparam logic [OPCODE_WIDTH-1:0] OP_EFI    = 5'd21;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_PRIME,
        SEQ_RUN,
        SEQ_CONST,
        SEQ_BRANCH_WAIT,
        SEQ_EFI_WAIT
    } seq_state_t;

    typedef enum logic [2:0] {
        CLS_NORMAL,
        CLS_CONST_FOLLOW,
        CLS_BRANCH,
        CLS_EFI,
        CLS_STOP,
        CLS_ILLEGAL
    } op_class_t;

    function automatic logic is_branch(input logic [OPCODE_WIDTH-1:0] opcode);
        return (opcode == OP_BGT) || (opcode == OP_BLE) ||
               (opcode == OP_BEQ) || (opcode == OP_BNE);
    endfunction

endpackage

// File: rtl/fcore_program_sequencer_classifier.sv
// Combinational opcode classifier shared by the program sequencer and the
// executor decode stage.
module fcore_opcode_classifier
    import fcore_program_sequencer_pkg::*;
(
    input  logic [OPCODE_WIDTH-1:0] opcode,
    output op_class_t               op_class
);

    always_comb begin
        op_class = CLS_NORMAL;
        if (opcode > OP_EFI)
            op_class = CLS_ILLEGAL;
        else if (opcode == OP_LDC)
            op_class = CLS_CONST_FOLLOW;
        else if (is_branch(opcode))
            op_class = CLS_BRANCH;
        else if (opcode == OP_EFI)
            op_class = CLS_EFI;
        else if (opcode == OP_STOP)
            op_class = CLS_STOP;
    end

endmodule

// File: rtl/fcore_program_sequencer.sv
// fCore fetch/issue controller: drives the program BRAM address, issues words
// to the executor, sequences LDC payloads and branch/EFI handshakes.
module fcore_program_sequencer #(
    parameter int unsigned PC_WIDTH          = 12,
    parameter int unsigned INSTRUCTION_WIDTH = 32,
    parameter int unsigned OPCODE_WIDTH      = fcore_program_sequencer_pkg::OPCODE_WIDTH,
    parameter int unsigned PROGRAM_DEPTH     = 4096
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    output logic [PC_WIDTH-1:0]          prog_addr,
    input  logic [INSTRUCTION_WIDTH-1:0] prog_data,
    output logic [INSTRUCTION_WIDTH-1:0] instruction,
    output logic                         instruction_valid,
    output logic                         instruction_is_const,
    input  logic                         branch_resolved,
    input  logic                         branch_taken,
    input  logic [PC_WIDTH-1:0]          branch_target,
    output logic                         efi_start,
    input  logic                         efi_done,
    output logic                         busy,
    output logic                         done,
    output logic                         overrun
);
    import fcore_program_sequencer_pkg::*;

    localparam logic [PC_WIDTH:0] DEPTH = (PC_WIDTH+1)'(PROGRAM_DEPTH);
    localparam logic [PC_WIDTH:0] ONE   = (PC_WIDTH+1)'(1);

    seq_state_t          state;
    op_class_t           op_class;
    logic [PC_WIDTH-1:0] fetched_pc;
    logic [PC_WIDTH-1:0] addr_next;
    logic [PC_WIDTH:0]   addr_step;
    logic [PC_WIDTH:0]   seq_pc;
    logic                seq_overrun;
    logic                target_overrun;

    fcore_opcode_classifier u_classifier (
        .opcode   (prog_data[OPCODE_WIDTH-1:0]),
        .op_class (op_class)
    );

    // The prefetch address never leaves the program; overrun is judged on the
    // successor of the word actually being issued (fetched_pc + 1).
    always_comb begin
        addr_step      = {1'b0, prog_addr} + ONE;
        addr_next      = (addr_step < DEPTH) ? addr_step[PC_WIDTH-1:0] : prog_addr;
        seq_pc         = {1'b0, fetched_pc} + ONE;
        seq_overrun    = (seq_pc >= DEPTH);
        target_overrun = ({1'b0, branch_target} >= DEPTH);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state                <= SEQ_IDLE;
            prog_addr            <= '0;
            fetched_pc           <= '0;
            instruction          <= '0;
            instruction_valid    <= 1'b0;
            instruction_is_const <= 1'b0;
            efi_start            <= 1'b0;
            busy                 <= 1'b0;
            done                 <= 1'b0;
            overrun              <= 1'b0;
        end else begin
            instruction_valid    <= 1'b0;
            instruction_is_const <= 1'b0;
            efi_start            <= 1'b0;
            done                 <= 1'b0;
            fetched_pc           <= prog_addr;
            case (state)
                SEQ_IDLE: begin
                    busy <= start;
                    if (start) begin
                        prog_addr <= '0;
                        overrun   <= 1'b0;
                        state     <= SEQ_PRIME;
                    end
                end
                SEQ_PRIME: begin
                    prog_addr <= addr_next;
                    state     <= SEQ_RUN;
                end
                SEQ_RUN: begin
                    instruction_valid <= 1'b1;
                    instruction       <= prog_data;
                    case (op_class)
                        CLS_BRANCH: begin
                            fetched_pc <= fetched_pc;
                            state      <= SEQ_BRANCH_WAIT;
                        end
                        CLS_EFI: begin
                            fetched_pc <= fetched_pc;
                            efi_start  <= 1'b1;
                            state      <= SEQ_EFI_WAIT;
                        end
                        CLS_STOP: begin
                            done  <= 1'b1;
                            state <= SEQ_IDLE;
                        end
                        default: begin
                            if (op_class == CLS_ILLEGAL)
                                instruction <= '0;
                            if (seq_overrun) begin
                                overrun <= 1'b1;
                                done    <= 1'b1;
                                state   <= SEQ_IDLE;
                            end else begin
                                prog_addr <= addr_next;
                                state     <= (op_class == CLS_CONST_FOLLOW) ? SEQ_CONST : SEQ_RUN;
                            end
                        end
                    endcase
                end
                SEQ_CONST: begin
                    instruction_valid    <= 1'b1;
                    instruction_is_const <= 1'b1;
                    instruction          <= prog_data;
                    if (seq_overrun) begin
                        overrun <= 1'b1;
                        done    <= 1'b1;
                        state   <= SEQ_IDLE;
                    end else begin
                        prog_addr <= addr_next;
                        state     <= SEQ_RUN;
                    end
                end
                SEQ_BRANCH_WAIT: begin
                    fetched_pc <= fetched_pc;
                    if (branch_resolved) begin
                        if (branch_taken ? target_overrun : seq_overrun) begin
                            overrun <= 1'b1;
                            done    <= 1'b1;
                            state   <= SEQ_IDLE;
                        end else begin
                            prog_addr <= branch_taken ? branch_target : seq_pc[PC_WIDTH-1:0];
                            state     <= SEQ_PRIME;
                        end
                    end
                end
                SEQ_EFI_WAIT: begin
                    fetched_pc <= fetched_pc;
                    // efi_start is still high in the first wait cycle; a done
                    // seen alongside it belongs to no request of ours.
                    if (efi_done && !efi_start) begin
                        if (seq_overrun) begin
                            overrun <= 1'b1;
                            done    <= 1'b1;
                            state   <= SEQ_IDLE;
                        end else begin
                            prog_addr <= seq_pc[PC_WIDTH-1:0];
                            state     <= SEQ_PRIME;
                        end
                    end
                end
                default: state <= SEQ_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fcore_program_sequencer.sv
// Directed bench for fcore_program_sequencer: a default-depth instance and a
// PROGRAM_DEPTH=8 instance, each fed by a 1-cycle-latency program memory.
module tb_fcore_program_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic [11:0] addr_a, addr_b;
    logic [31:0] data_a = '0, data_b = '0;
    logic [31:0] instr_a, instr_b;
    logic        valid_a, valid_b, const_a, const_b;
    logic        branch_resolved = 1'b0, branch_taken = 1'b0;
    logic [11:0] branch_target = '0;
    logic        efi_done = 1'b0;
    logic        efi_a, efi_b, busy_a, busy_b, done_a, done_b, ovr_a, ovr_b;

    logic [31:0] mem_a [0:4095];
    logic [31:0] mem_b [0:4095];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] log_word [$];
    logic        log_const [$];
    int          log_cyc [$];
    int          efi_pulses = 0, done_pulses = 0;
    int          issued_b = 0, done_pulses_b = 0;
    logic [31:0] last_b = '0;

    fcore_program_sequencer u_dut_a (
        .clock(clock), .reset(reset), .start(start_a),
        .prog_addr(addr_a), .prog_data(data_a),
        .instruction(instr_a), .instruction_valid(valid_a), .instruction_is_const(const_a),
        .branch_resolved(branch_resolved), .branch_taken(branch_taken), .branch_target(branch_target),
        .efi_start(efi_a), .efi_done(efi_done),
        .busy(busy_a), .done(done_a), .overrun(ovr_a)
    );

    fcore_program_sequencer #(.PROGRAM_DEPTH(8)) u_dut_b (
        .clock(clock), .reset(reset), .start(start_b),
        .prog_addr(addr_b), .prog_data(data_b),
        .instruction(instr_b), .instruction_valid(valid_b), .instruction_is_const(const_b),
        .branch_resolved(branch_resolved), .branch_taken(branch_taken), .branch_target(branch_target),
        .efi_start(efi_b), .efi_done(efi_done),
        .busy(busy_b), .done(done_b), .overrun(ovr_b)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;
    always @(posedge clock) data_a <= mem_a[addr_a];
    always @(posedge clock) data_b <= mem_b[addr_b];

    always @(negedge clock) begin
        if (valid_a) begin
            log_word.push_back(instr_a);
            log_const.push_back(const_a);
            log_cyc.push_back(cyc);
        end
        if (efi_a)  efi_pulses++;
        if (done_a) done_pulses++;
        if (valid_b) begin
            issued_b++;
            last_b = instr_b;
        end
        if (done_b) done_pulses_b++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        log_word.delete();
        log_const.delete();
        log_cyc.delete();
        efi_pulses  = 0;
        done_pulses = 0;
    endtask

    task automatic clear_mem_a();
        for (int i = 0; i < 64; i++) mem_a[i] = '0;
    endtask

    task automatic pulse_start_a();
        @(negedge clock); start_a = 1'b1;
        @(negedge clock); start_a = 1'b0;
    endtask

    task automatic wait_done_a(input string tag, input int bound);
        int n = 0;
        do begin @(negedge clock); n++; end while (!done_a && n < bound);
        check(tag, 32'(done_a), 32'd1);
        @(negedge clock);
    endtask

    task automatic wait_opcode_a(input string tag, input logic [4:0] op, input int bound);
        int n = 0;
        do begin @(negedge clock); n++; end while (!(valid_a && instr_a[4:0] == op) && n < bound);
        check(tag, 32'(valid_a && instr_a[4:0] == op), 32'd1);
    endtask

    task automatic load_branch_prog();
        clear_mem_a();
        mem_a[0]  = 32'h3000_0001;
        mem_a[1]  = 32'h3010_0001;
        mem_a[2]  = 32'h3020_0001;
        mem_a[3]  = 32'h3030_0001;
        mem_a[4]  = 32'h3040_0001;
        mem_a[5]  = 32'h3050_000B;
        mem_a[6]  = 32'h3060_000C;
        mem_a[20] = 32'h3200_0002;
        mem_a[21] = 32'h3210_000C;
    endtask

    task automatic test_linear();
        logic [31:0] exp_w [4];
        exp_w = '{32'h1000_0001, 32'h1100_0002, 32'h1200_0003, 32'h1300_000C};
        clear_mem_a();
        for (int i = 0; i < 4; i++) mem_a[i] = exp_w[i];
        // stray branch resolution while running must be ignored
        branch_resolved = 1'b1; branch_taken = 1'b1; branch_target = 12'd30;
        @(negedge clock); start_a = 1'b1;
        @(posedge clock); #1; start_a = 1'b0;
        check("lin_prime_busy", 32'(busy_a), 32'd1);
        check("lin_prime_valid", 32'(valid_a), 32'd0);
        check("lin_prime_addr", 32'(addr_a), 32'd0);
        @(posedge clock); #1;
        check("lin_run_valid", 32'(valid_a), 32'd0);
        check("lin_run_addr", 32'(addr_a), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            check($sformatf("lin_valid%0d", i), 32'(valid_a), 32'd1);
            check($sformatf("lin_word%0d", i), instr_a, exp_w[i]);
            check($sformatf("lin_done%0d", i), 32'(done_a), (i == 3) ? 32'd1 : 32'd0);
        end
        check("lin_busy_at_done", 32'(busy_a), 32'd1);
        check("lin_addr_at_stop", 32'(addr_a), 32'd4);
        @(posedge clock); #1;
        check("lin_busy_after", 32'(busy_a), 32'd0);
        check("lin_done_after", 32'(done_a), 32'd0);
        check("lin_valid_after", 32'(valid_a), 32'd0);
        branch_resolved = 1'b0; branch_taken = 1'b0; branch_target = '0;
    endtask

    task automatic test_ldc();
        clear_mem_a();
        mem_a[0] = 32'h2000_0006;
        mem_a[1] = 32'h0000_000F;
        mem_a[2] = 32'h2200_0006;
        mem_a[3] = 32'h0000_0006;
        mem_a[4] = 32'h2400_000C;
        clear_log();
        pulse_start_a();
        wait_done_a("ldc_done", 40);
        check("ldc_count", 32'(log_word.size()), 32'd5);
        check("ldc_w0", log_word[0], 32'h2000_0006);
        check("ldc_c0", 32'(log_const[0]), 32'd0);
        check("ldc_w1", log_word[1], 32'h0000_000F);
        check("ldc_c1", 32'(log_const[1]), 32'd1);
        check("ldc_w2", log_word[2], 32'h2200_0006);
        check("ldc_c2", 32'(log_const[2]), 32'd0);
        check("ldc_w3", log_word[3], 32'h0000_0006);
        check("ldc_c3", 32'(log_const[3]), 32'd1);
        check("ldc_w4", log_word[4], 32'h2400_000C);
        check("ldc_c4", 32'(log_const[4]), 32'd0);
        check("ldc_done_pulses", 32'(done_pulses), 32'd1);
    endtask

    task automatic test_branch(input logic taken);
        string t;
        t = taken ? "bt" : "bn";
        load_branch_prog();
        clear_log();
        pulse_start_a();
        wait_opcode_a({t, "_seen"}, 5'd11, 40);
        repeat (3) @(negedge clock);
        branch_resolved = 1'b1; branch_taken = taken; branch_target = taken ? 12'd20 : 12'd9;
        @(negedge clock);
        branch_resolved = 1'b0; branch_taken = 1'b0; branch_target = '0;
        wait_done_a({t, "_done"}, 40);
        check({t, "_count"}, 32'(log_word.size()), taken ? 32'd8 : 32'd7);
        check({t, "_bne"}, log_word[5], 32'h3050_000B);
        check({t, "_next"}, log_word[6], taken ? 32'h3200_0002 : 32'h3060_000C);
        check({t, "_gap"}, 32'(log_cyc[6] - log_cyc[5]), 32'd6);
        if (taken) check({t, "_stop"}, log_word[7], 32'h3210_000C);
    endtask

    task automatic test_efi();
        clear_mem_a();
        mem_a[0] = 32'h4000_0001;
        mem_a[1] = 32'h4010_0001;
        mem_a[2] = 32'h4020_0015;
        mem_a[3] = 32'h4030_0002;
        mem_a[4] = 32'h4040_000C;
        clear_log();
        efi_done = 1'b1;
        pulse_start_a();
        wait_opcode_a("efi_seen", 5'd21, 40);
        check("efi_start_with_issue", 32'(efi_a), 32'd1);
        @(negedge clock); efi_done = 1'b0;
        repeat (9) @(negedge clock);
        efi_done = 1'b1;
        @(negedge clock); efi_done = 1'b0;
        wait_done_a("efi_done", 40);
        check("efi_count", 32'(log_word.size()), 32'd5);
        check("efi_w1", log_word[1], 32'h4010_0001);
        check("efi_w3", log_word[3], 32'h4030_0002);
        check("efi_gap", 32'(log_cyc[3] - log_cyc[2]), 32'd13);
        check("efi_pulses", 32'(efi_pulses), 32'd1);
    endtask

    task automatic test_illegal();
        clear_mem_a();
        mem_a[0] = 32'h7000_001F;
        mem_a[1] = 32'h7010_000C;
        clear_log();
        pulse_start_a();
        wait_done_a("ill_done", 20);
        check("ill_count", 32'(log_word.size()), 32'd2);
        check("ill_w0", log_word[0], 32'h0000_0000);
        check("ill_w1", log_word[1], 32'h7010_000C);
    endtask

    task automatic test_overrun();
        int n;
        for (int i = 0; i < 8; i++) mem_b[i] = 32'h5000_0001 | (32'(i) << 8);
        @(negedge clock); start_b = 1'b1;
        @(negedge clock); start_b = 1'b0;
        n = 0;
        do begin @(negedge clock); n++; end while (!done_b && n < 40);
        check("ovr_done", 32'(done_b), 32'd1);
        check("ovr_valid_with_done", 32'(valid_b), 32'd1);
        check("ovr_flag", 32'(ovr_b), 32'd1);
        @(negedge clock);
        check("ovr_issued", 32'(issued_b), 32'd8);
        check("ovr_last", last_b, 32'h5000_0701);
        check("ovr_done_pulses", 32'(done_pulses_b), 32'd1);
        check("ovr_sticky", 32'(ovr_b), 32'd1);
        check("ovr_busy_low", 32'(busy_b), 32'd0);
        start_b = 1'b1;
        @(posedge clock); #1; start_b = 1'b0;
        check("ovr_cleared", 32'(ovr_b), 32'd0);
        n = 0;
        do begin @(negedge clock); n++; end while (!done_b && n < 40);
        check("ovr_rerun_done", 32'(done_b), 32'd1);
    endtask

    task automatic test_reset_mid();
        int d;
        load_branch_prog();
        clear_log();
        pulse_start_a();
        wait_opcode_a("rst_bne_seen", 5'd11, 40);
        d = done_pulses;
        #2 reset = 1'b0;
        #1;
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_valid", 32'(valid_a), 32'd0);
        check("rst_instr", instr_a, 32'd0);
        check("rst_addr", 32'(addr_a), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check("rst_no_done", 32'(done_pulses), 32'(d));
        clear_log();
        pulse_start_a();
        wait_opcode_a("rst_rerun_bne", 5'd11, 40);
        check("rst_first_word", log_word[0], 32'h3000_0001);
        branch_resolved = 1'b1; branch_taken = 1'b0;
        @(negedge clock); branch_resolved = 1'b0;
        wait_done_a("rst_rerun_done", 40);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        repeat (3) @(negedge clock);
        check("reset_busy", 32'(busy_a), 32'd0);
        check("reset_addr", 32'(addr_a), 32'd0);
        check("reset_instr", instr_a, 32'd0);
        check("reset_flags", {28'd0, valid_a, const_a, efi_a, done_a}, 32'd0);
        check("reset_overrun", 32'(ovr_a), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        test_linear();
        test_ldc();
        test_branch(1'b1);
        test_branch(1'b0);
        test_efi();
        test_illegal();
        test_overrun();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
